noise_ctrl: RTL and testbench

Run controller for the Gaussian noise datapath (uniform RNG, address generator, transform). It issues the start pulse, holds off output during the table warm-up interval, and then streams a programmed number of 24-bit noise samples (or an unbounded stream) over a valid/ready interface. Backpressure is absorbed by a small output FIFO and a datapath clock-enable.

---
 rtl/noise_pkg.sv | 19 +
 rtl/noise_fifo.sv | 68 ++++++
 rtl/noise_ctrl.sv | 151 +++++++++++++++
 tb/tb_noise_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared types and default parameters for the Gaussian noise run controller.
// The controller and its output FIFO both import this package.
package noise_pkg;

    localparam int DW_DEF         = 24;
    localparam int CNT_W_DEF      = 16;
    localparam int WARMUP_DEF     = 1032;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WARM  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/noise_fifo.sv
// Small synchronous output FIFO. The head entry is read straight from the
// storage registers, so it is visible the cycle after it is pushed.
module noise_fifo
    import noise_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       i_ck,
    input  logic                       i_rb,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_din,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_dout,
    output logic [$clog2(DEPTH):0]     o_occ,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [OW-1:0] r_occ;
    logic          w_empty;
    logic          w_full;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_ck) begin
        if (i_rb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + AW'(1'b1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1'b1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OW'(1'b1);
                2'b01:   r_occ <= r_occ - OW'(1'b1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_occ   = r_occ;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/noise_ctrl.sv
// Run controller for the Gaussian noise datapath: start pulse, warm-up hold-off,
// then a counted (or open-ended) sample stream over valid/ready with backpressure.
module noise_ctrl
    import noise_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WARMUP     = WARMUP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             CK,
    input  logic             RB,
    input  logic             cmd_go,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_stop,
    output logic             ST,
    output logic             EN,
    input  logic [DW-1:0]    C,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done
);

    localparam int OW     = $clog2(FIFO_DEPTH) + 1;
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_iss;
    logic [CNT_W-1:0] r_dlv;
    logic [WARM_W-1:0] r_warm;
    logic             r_en_q;

    logic             w_en;
    logic             w_room;
    logic [OW:0]      w_fill;
    logic [OW-1:0]    w_occ;
    logic             w_empty;
    logic             w_full;
    logic [DW-1:0]    w_dout;
    logic             w_pop;
    logic             w_drain_last;

    noise_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_ck    (CK),
        .i_rb    (RB),
        .i_push  (r_en_q),
        .i_din   (C),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_occ   (w_occ),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_pop  = !w_empty && m_ready;
    // Each sample still in the datapath pipe owns a FIFO slot before the next is issued.
    assign w_fill = {1'b0, w_occ} + {{OW{1'b0}}, r_en_q};
    assign w_room = !w_full && (w_fill < (OW + 1)'(FIFO_DEPTH));
    // Last pop (or nothing left at all) while no sample is still in flight.
    assign w_drain_last = !r_en_q && (w_empty || ((w_occ == OW'(1'b1)) && m_ready));

    // Datapath clock-enable.
    always_comb begin
        w_en = 1'b0;
        case (r_state)
            START, WARM: w_en = 1'b1;
            RUN:         w_en = ((r_len == '0) || (r_iss != '0)) && w_room;
            default:     w_en = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_go) w_state_nxt = START;
                else        w_state_nxt = IDLE;
            end
            START: w_state_nxt = WARM;
            WARM: begin
                if (cmd_stop)            w_state_nxt = DONE;
                else if (r_warm == '0)   w_state_nxt = RUN;
                else                     w_state_nxt = WARM;
            end
            RUN: begin
                if (cmd_stop || ((r_len != '0) && (r_iss == CNT_W'(1'b1)) && w_en))
                    w_state_nxt = DRAIN;
                else
                    w_state_nxt = RUN;
            end
            DRAIN: begin
                if (w_drain_last) w_state_nxt = DONE;
                else              w_state_nxt = DRAIN;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, run counters and the in-flight flag.
    always_ff @(posedge CK) begin
        if (RB) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_iss   <= '0;
            r_dlv   <= '0;
            r_warm  <= '0;
            r_en_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Only enables issued in RUN produce samples; warm-up output is discarded.
            r_en_q  <= (r_state == RUN) && w_en;
            case (r_state)
                IDLE: begin
                    if (cmd_go) begin
                        r_len <= cmd_len;
                        r_iss <= cmd_len;
                        r_dlv <= cmd_len;
                    end
                end
                START: r_warm <= WARM_W'(WARMUP - 1);
                WARM: begin
                    if (r_warm != '0) r_warm <= r_warm - WARM_W'(1'b1);
                end
                RUN: begin
                    if (w_en && (r_len != '0) && (r_iss != '0))
                        r_iss <= r_iss - CNT_W'(1'b1);
                end
                default: r_warm <= r_warm;
            endcase
            if (w_pop && (r_len != '0) && (r_dlv != '0))
                r_dlv <= r_dlv - CNT_W'(1'b1);
        end
    end

    assign ST      = (r_state == START);
    assign EN      = w_en;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign m_valid = !w_empty;
    assign m_data  = w_dout;

endmodule

// File: tb/tb_noise_ctrl.sv
// Scoreboard bench for noise_ctrl: an EN-gated reference datapath feeds C and
// queues each sample issued in RUN; every handshake pops and compares.
module tb_noise_ctrl;

    localparam int DW     = 24;
    localparam int CNT_W  = 16;
    localparam int WARMUP = 1032;
    localparam int DEPTH  = 4;

    logic             CK = 1'b0;
    logic             RB = 1'b1;
    logic             cmd_go = 1'b0;
    logic             cmd_stop = 1'b0;
    logic             m_ready = 1'b0;
    logic [CNT_W-1:0] cmd_len = '0;
    logic [DW-1:0]    C = '0;
    logic             ST, EN, m_valid, busy, done;
    logic [DW-1:0]    m_data;

    noise_ctrl dut (
        .CK       (CK),
        .RB       (RB),
        .cmd_go   (cmd_go),
        .cmd_len  (cmd_len),
        .cmd_stop (cmd_stop),
        .ST       (ST),
        .EN       (EN),
        .C        (C),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 CK = ~CK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mix(input int k);
        logic [31:0] x;
        x = 32'(k) * 32'h9E3779B1;
        x = x ^ (x >> 15);
        return x[DW-1:0];
    endfunction

    logic [DW-1:0] exp_q[$];
    int            tx_cyc_q[$];
    int cyc = 0;
    int g = 0;
    bit pend = 1'b0;
    int en_cnt = 0, st_cnt = 0, st_cyc = -1, first_v_cyc = -1;
    int done_cnt = 0, done_cyc = -1, tx_cnt = 0, max_infl = 0, go_cyc = 0;

    // Reference datapath: a new sample appears on C the cycle after each EN.
    always @(posedge CK) begin
        cyc <= cyc + 1;
        if (pend) C <= mix(g);
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge CK) begin
        if (!RB) begin
            if (ST) begin
                st_cnt++;
                if (st_cyc < 0) st_cyc = cyc;
            end
            if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                tx_cnt++;
                tx_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check_val("sb_empty", exp_q.size(), 1);
                else                   check_val("sample", m_data, exp_q.pop_front());
            end
        end
        pend = 1'b0;
        if (EN) begin
            pend = 1'b1;
            g++;
            en_cnt++;
            if (en_cnt > WARMUP + 1) exp_q.push_back(mix(g));
        end
        if (exp_q.size() > max_infl) max_infl = exp_q.size();
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    function automatic int tx_span(input int from);
        if (tx_cyc_q.size() <= from) return -1;
        return tx_cyc_q[tx_cyc_q.size() - 1] - tx_cyc_q[from];
    endfunction

    task automatic begin_run(input int len);
        exp_q.delete();
        tx_cyc_q.delete();
        en_cnt = 0; st_cnt = 0; st_cyc = -1; first_v_cyc = -1;
        done_cnt = 0; done_cyc = -1; tx_cnt = 0; max_infl = 0;
        cmd_len = CNT_W'(len);
        cmd_go  = 1'b1;
        go_cyc  = cyc;
        tick();
        cmd_go  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (toggle) m_ready = ~m_ready;
            tick();
            n++;
        end
        repeat (3) tick();
        check_val("done_pulses", done_cnt, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, k, rel_cyc, stop_cyc;
        // Reset state
        repeat (3) tick();
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_en", EN, 0);
        check_val("rst_st", ST, 0);
        check_val("rst_done", done, 0);
        check_val("rst_m_data", m_data, 0);
        RB = 1'b0;
        tick();

        // Five samples, consumer always ready
        m_ready = 1'b1;
        begin_run(5);
        wait_done(WARMUP + 100, 1'b0);
        check_val("b_st_cycle", st_cyc - go_cyc, 1);
        check_val("b_st_count", st_cnt, 1);
        check_val("b_first_valid", first_v_cyc - go_cyc, WARMUP + 4);
        check_val("b_tx_count", tx_cnt, 5);
        check_val("b_tx_back_to_back", tx_span(0), 4);
        check_val("b_done_latency", done_cyc - tx_cyc_q[tx_cyc_q.size() - 1], 1);
        check_val("b_run_en_cycles", en_cnt - (WARMUP + 1), 5);
        check_val("b_sb_left", exp_q.size(), 0);
        check_val("b_busy_after", busy, 0);

        // Twenty samples, ready toggling every cycle
        m_ready = 1'b1;
        begin_run(20);
        wait_done(WARMUP + 200, 1'b1);
        check_val("c_tx_count", tx_cnt, 20);
        check_val("c_inflight_le_depth", max_infl <= DEPTH, 1);
        check_val("c_sb_left", exp_q.size(), 0);
        check_val("c_run_en_cycles", en_cnt - (WARMUP + 1), 20);

        // Continuous stream stopped after 100 transfers
        m_ready = 1'b1;
        begin_run(0);
        n = 0;
        while (tx_cnt < 100 && n < WARMUP + 300) begin
            tick();
            n++;
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        wait_done(50, 1'b0);
        check_val("d_tx_ge_100", tx_cnt >= 100, 1);
        check_val("d_all_issued_delivered", tx_cnt, en_cnt - (WARMUP + 1));
        check_val("d_sb_left", exp_q.size(), 0);
        check_val("d_done_latency", done_cyc - tx_cyc_q[tx_cyc_q.size() - 1], 1);
        check_val("d_busy_after", busy, 0);

        // Stop during warm-up; a go mid-run is ignored
        m_ready = 1'b1;
        begin_run(10);
        repeat (10) tick();
        cmd_go = 1'b1; cmd_len = CNT_W'(3);
        tick();
        cmd_go = 1'b0;
        repeat (10) tick();
        cmd_stop = 1'b1;
        stop_cyc = cyc;
        tick();
        cmd_stop = 1'b0;
        wait_done(20, 1'b0);
        check_val("e_done_latency", done_cyc - stop_cyc, 1);
        check_val("e_no_valid", first_v_cyc, -1);
        check_val("e_tx_count", tx_cnt, 0);
        check_val("e_st_count", st_cnt, 1);
        check_val("e_en_cycles", en_cnt, stop_cyc - go_cyc);
        repeat (3) tick();
        check_val("e_busy_after", busy, 0);

        // 50-cycle stall in RUN
        m_ready = 1'b1;
        begin_run(30);
        n = 0;
        while (tx_cnt < 5 && n < WARMUP + 100) begin
            tick();
            n++;
        end
        m_ready = 1'b0;
        repeat (50) tick();
        check_val("f_stall_buffered", exp_q.size(), DEPTH);
        check_val("f_stall_en_low", EN, 0);
        k = tx_cnt;
        m_ready = 1'b1;
        rel_cyc = cyc;
        wait_done(100, 1'b0);
        check_val("f_tx_count", tx_cnt, 30);
        check_val("f_first_after_release", (tx_cyc_q.size() > k) ? tx_cyc_q[k] - rel_cyc : -1, 0);
        check_val("f_no_gap", tx_span(k), 30 - 1 - k);
        check_val("f_sb_left", exp_q.size(), 0);

        // Reset in RUN with m_valid high
        m_ready = 1'b0;
        begin_run(0);
        n = 0;
        while (first_v_cyc < 0 && n < WARMUP + 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_val("g_valid_before", m_valid, 1);
        RB = 1'b1;
        tick();
        check_val("g_m_valid", m_valid, 0);
        check_val("g_busy", busy, 0);
        check_val("g_en", EN, 0);
        check_val("g_done", done, 0);
        RB = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check_val("g_no_done", done_cnt, 0);
        check_val("g_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
